// File: rtl/alu_pkg.sv
// Shared opcode encodings and flag bit positions for the add/subtract pipeline.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_ADC = 3'b010;
  localparam logic [2:0] OP_SBC = 3'b011;
  localparam logic [2:0] OP_CMP = 3'b100;

  localparam int FLAGS_W = 4;
  localparam int FLG_C   = 3;
  localparam int FLG_V   = 2;
  localparam int FLG_N   = 1;
  localparam int FLG_Z   = 0;

endpackage

// File: rtl/addsub_pipe_if.sv
// Operand/result handshake bundle for addsub_pipe, including the synchronous flush.
interface addsub_pipe_if
  import alu_pkg::*;
#(
  parameter int WIDTH = 9,
  parameter int OP_W  = 3
);

  logic               flush;
  logic               in_valid;
  logic               in_ready;
  logic [OP_W-1:0]    in_op;
  logic [WIDTH-1:0]   in_a;
  logic [WIDTH-1:0]   in_b;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out_sum;
  logic [FLAGS_W-1:0] out_flags;
  logic               out_op_err;

  modport master (
    output flush, in_valid, in_op, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_sum, out_flags, out_op_err
  );

  modport slave (
    input  flush, in_valid, in_op, in_a, in_b, out_ready,
    output in_ready, out_valid, out_sum, out_flags, out_op_err
  );

endinterface

// File: rtl/addsub_core.sv
// Combinational ripple-carry adder: sum = a + (b ^ {WIDTH{inv}}) + cin, with carry-out and signed overflow.
module addsub_core #(
  parameter int WIDTH = 9
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             inv,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  logic [WIDTH-1:0] b_x;
  logic [WIDTH:0]   carry;

  assign b_x      = b ^ {WIDTH{inv}};
  assign carry[0] = cin;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_full_adder
    assign sum[gi]     = a[gi] ^ b_x[gi] ^ carry[gi];
    assign carry[gi+1] = (a[gi] & b_x[gi]) | (carry[gi] & (a[gi] ^ b_x[gi]));
  end

  assign cout = carry[WIDTH];
  // Overflow is judged on the effective (possibly inverted) second operand.
  assign ovf  = (a[WIDTH-1] == b_x[WIDTH-1]) & (sum[WIDTH-1] != a[WIDTH-1]);

endmodule

// File: rtl/addsub_pipe.sv
// Two-stage valid/ready add/subtract unit with carry chaining and C/V/N/Z flags.
// Define SATURATE_EN to clamp ADD/SUB/ADC/SBC results to the signed range on overflow.
module addsub_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 9,
  parameter int OP_W  = 3
) (
  input logic         clk,
  input logic         rst,
  addsub_pipe_if.slave bus
);

  logic               s1_valid_reg;
  logic [OP_W-1:0]    s1_op_reg;
  logic [WIDTH-1:0]   s1_a_reg;
  logic [WIDTH-1:0]   s1_b_reg;
  logic               carry_reg;
  logic               out_valid_reg;
  logic [WIDTH-1:0]   out_sum_reg;
  logic [FLAGS_W-1:0] out_flags_reg;
  logic               out_err_reg;

  logic en2, en1, accept;
  logic inv, cin, is_cmp, is_err;
  logic [WIDTH-1:0]   raw_sum, res_sum, sum_next;
  logic               cout, ovf;
  logic [FLAGS_W-1:0] flags_next;

  assign en2    = !out_valid_reg | bus.out_ready;
  assign en1    = !s1_valid_reg | en2;
  assign accept = bus.in_valid & bus.in_ready;

  assign bus.in_ready   = en1 & !bus.flush;
  assign bus.out_valid  = out_valid_reg;
  assign bus.out_sum    = out_sum_reg;
  assign bus.out_flags  = out_flags_reg;
  assign bus.out_op_err = out_err_reg;

  always_comb begin
    inv    = 1'b0;
    cin    = 1'b0;
    is_cmp = 1'b0;
    is_err = 1'b0;
    case (s1_op_reg)
      OP_W'(OP_ADD): ;
      OP_W'(OP_SUB): begin inv = 1'b1; cin = 1'b1; end
      OP_W'(OP_ADC): cin = carry_reg;
      OP_W'(OP_SBC): begin inv = 1'b1; cin = carry_reg; end
      OP_W'(OP_CMP): begin inv = 1'b1; cin = 1'b1; is_cmp = 1'b1; end
      default:       is_err = 1'b1;
    endcase
  end

  addsub_core #(.WIDTH(WIDTH)) u_core (
    .a    (s1_a_reg),
    .b    (s1_b_reg),
    .inv  (inv),
    .cin  (cin),
    .sum  (raw_sum),
    .cout (cout),
    .ovf  (ovf)
  );

`ifdef SATURATE_EN
  logic sat_ok;
  assign sat_ok = !is_cmp & !is_err;

  // Overflow only happens when both operands share a sign, so a's sign picks the rail.
  always_comb begin
    res_sum = raw_sum;
    if (sat_ok && ovf) begin
      res_sum = s1_a_reg[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end
`else
  assign res_sum = raw_sum;
`endif

  always_comb begin
    flags_next        = '0;
    flags_next[FLG_C] = cout;
    flags_next[FLG_V] = ovf;
    flags_next[FLG_N] = res_sum[WIDTH-1];
    flags_next[FLG_Z] = (res_sum == '0);
  end

  assign sum_next = is_cmp ? s1_a_reg : res_sum;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_reg  <= 1'b0;
      s1_op_reg     <= '0;
      s1_a_reg      <= '0;
      s1_b_reg      <= '0;
      carry_reg     <= 1'b0;
      out_valid_reg <= 1'b0;
      out_sum_reg   <= '0;
      out_flags_reg <= '0;
      out_err_reg   <= 1'b0;
    end else if (bus.flush) begin
      s1_valid_reg  <= 1'b0;
      out_valid_reg <= 1'b0;
      carry_reg     <= 1'b0;
    end else begin
      if (en1) begin
        s1_valid_reg <= accept;
        if (accept) begin
          s1_op_reg <= bus.in_op;
          s1_a_reg  <= bus.in_a;
          s1_b_reg  <= bus.in_b;
        end
      end
      if (en2) begin
        out_valid_reg <= s1_valid_reg;
        if (s1_valid_reg) begin
          out_sum_reg   <= sum_next;
          out_flags_reg <= flags_next;
          out_err_reg   <= is_err;
          // Carry recorded here is exactly what the next ADC/SBC in S1 consumes.
          if (!is_err) begin
            carry_reg <= cout;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_addsub_pipe.sv
// Scoreboard bench for addsub_pipe (WIDTH=8): directed corner cases, backpressure, flush, reset, random traffic.
module tb_addsub_pipe;

  localparam int W  = 8;
  localparam int OW = 3;

  typedef struct {
    logic [7:0] sum;
    logic [3:0] flags;
    logic       err;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  addsub_pipe_if #(.WIDTH(W), .OP_W(OW)) bus ();

  addsub_pipe #(.WIDTH(W), .OP_W(OW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t exp_q[$];
  int   checks  = 0;
  int   errors  = 0;
  int   accepts = 0;
  int   mc      = 0;
  bit   rand_done = 0;
  exp_t mon_e;

  // Reference: plain integer arithmetic on unsigned and signed views of the operands.
  function automatic exp_t model(int op, int a, int b);
    exp_t e;
    int sa, sbv, r, sr, c, v, res, bor, ci;
    sa  = (a > 127) ? a - 256 : a;
    sbv = (b > 127) ? b - 256 : b;
    if (op == 1 || op == 3 || op == 4) begin
      bor = (op == 3) ? 1 - mc : 0;
      r   = a - b - bor;
      sr  = sa - sbv - bor;
      c   = (r >= 0) ? 1 : 0;
    end else begin
      ci = (op == 2) ? mc : 0;
      r  = a + b + ci;
      sr = sa + sbv + ci;
      c  = (r > 255) ? 1 : 0;
    end
    res = r & 255;
    v   = (sr > 127 || sr < -128) ? 1 : 0;
`ifdef SATURATE_EN
    if (op <= 3 && v == 1) res = (sr > 0) ? 127 : 128;
`endif
    e.sum      = (op == 4) ? 8'(a) : 8'(res);
    e.flags[3] = (c != 0);
    e.flags[2] = (v != 0);
    e.flags[1] = (res >= 128);
    e.flags[0] = (res == 0);
    e.err      = (op > 4);
    if (op <= 4) mc = c;
    return e;
  endfunction

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input int op, input int a, input int b, input bit use_exp, input exp_t ex);
    int  waitc = 0;
    bit  done  = 0;
    bus.in_valid = 1'b1;
    bus.in_op    = OW'(op);
    bus.in_a     = W'(a);
    bus.in_b     = W'(b);
    while (!done) begin
      @(negedge clk);
      if (bus.in_ready) begin
        exp_q.push_back(use_exp ? ex : model(op, a, b));
        accepts++;
        done = 1;
      end else begin
        waitc++;
        if (waitc > 200) begin
          checks++;
          errors++;
          $display("FAIL accept_timeout: op %0d not accepted, expected acceptance within 200 cycles", op);
          done = 1;
        end
      end
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic send_m(input int op, input int a, input int b);
    exp_t dummy;
    dummy = '{8'h00, 4'h0, 1'b0};
    send_beat(op, a, b, 1'b0, dummy);
  endtask

  task automatic send_x(input int op, input int a, input int b, input int s, input int f, input int er);
    exp_t ex;
    ex.sum   = 8'(s);
    ex.flags = 4'(f);
    ex.err   = er[0];
    send_beat(op, a, b, 1'b1, ex);
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() > 0 && t < 500) begin
      cyc(1);
      t++;
    end
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d results outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
    cyc(1);
  endtask

  // Monitor: compares every presented result (stalled or not) against the queue head.
  always @(negedge clk) begin
    if (!rst && bus.out_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_beat: sum %0h flags %0h err %0b, expected no output", bus.out_sum, bus.out_flags, bus.out_op_err);
      end else begin
        mon_e = exp_q[0];
        if (bus.out_sum !== mon_e.sum || bus.out_flags !== mon_e.flags || bus.out_op_err !== mon_e.err) begin
          errors++;
          $display("FAIL result: sum %0h flags %0h err %0b, expected sum %0h flags %0h err %0b",
                   bus.out_sum, bus.out_flags, bus.out_op_err, mon_e.sum, mon_e.flags, mon_e.err);
        end else begin
          $display("beat ok: sum %0h flags %0h err %0b ready %0b", bus.out_sum, bus.out_flags, bus.out_op_err, bus.out_ready);
        end
        if (bus.out_ready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, op;
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_op     = '0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.out_ready = 1'b1;
    rst           = 1'b1;
    cyc(3);
    chk("reset_out_valid", int'(bus.out_valid), 0);
    chk("reset_out_sum", int'(bus.out_sum), 0);
    chk("reset_out_flags", int'(bus.out_flags), 0);
    chk("reset_out_op_err", int'(bus.out_op_err), 0);
    rst = 1'b0;
    cyc(1);
    chk("reset_in_ready", int'(bus.in_ready), 1);

    // Directed corner cases, back-to-back.
`ifdef SATURATE_EN
    send_x(0, 'h7F, 'h01, 'h7F, 4'b0100, 0);
`else
    send_x(0, 'h7F, 'h01, 'h80, 4'b0110, 0);
`endif
    send_x(1, 'h00, 'h01, 'hFF, 4'b0010, 0);
    send_x(4, 'h05, 'h05, 'h05, 4'b1001, 0);
    send_x(7, 'h03, 'h04, 'h07, 4'b0000, 1);
    send_x(2, 'h00, 'h00, 'h01, 4'b0000, 0);
    send_x(0, 'hFF, 'h01, 'h00, 4'b1001, 0);
    send_x(2, 'h00, 'h00, 'h01, 4'b0000, 0);
    send_x(3, 'h00, 'h00, 'hFF, 4'b0010, 0);
    drain();

    // Flush with both stages full: input refused, pipeline emptied, carry cleared.
    send_x(0, 'hFF, 'h01, 'h00, 4'b1001, 0);
    drain();
    bus.out_ready = 1'b0;
    send_x(0, 'h01, 'h01, 'h02, 4'b0000, 0);
    send_x(0, 'h02, 'h02, 'h04, 4'b0000, 0);
    bus.flush    = 1'b1;
    bus.in_valid = 1'b1;
    @(negedge clk);
    chk("flush_in_ready", int'(bus.in_ready), 0);
    @(posedge clk);
    #1;
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    exp_q.delete();
    chk("flush_out_valid", int'(bus.out_valid), 0);
    bus.out_ready = 1'b1;
    send_x(2, 'h00, 'h00, 'h00, 4'b0001, 0);
    drain();
    mc = 0;

    // Backpressure: four beats offered while the output is stalled.
    bus.out_ready = 1'b0;
    a0 = accepts;
    fork
      begin
        for (int i = 0; i < 4; i++) send_m(0, 16 * i + 3, i);
      end
      begin
        repeat (4) @(posedge clk);
        #2;
        chk("bp_accepts", accepts - a0, 2);
        chk("bp_in_ready", int'(bus.in_ready), 0);
        chk("bp_out_valid", int'(bus.out_valid), 1);
        bus.out_ready = 1'b1;
      end
    join
    drain();

    // Asynchronous reset with both stages full, after carry_q was set.
    send_m(0, 'hFF, 'h01);
    drain();
    bus.out_ready = 1'b0;
    send_m(0, 'h10, 'h20);
    send_m(1, 'h30, 'h05);
    rst = 1'b1;
    #1;
    chk("midreset_out_valid", int'(bus.out_valid), 0);
    exp_q.delete();
    mc = 0;
    cyc(2);
    rst = 1'b0;
    cyc(1);
    chk("midreset_in_ready", int'(bus.in_ready), 1);
    chk("midreset_out_valid_after", int'(bus.out_valid), 0);
    bus.out_ready = 1'b1;
    send_x(2, 'h00, 'h00, 'h00, 4'b0001, 0);
    drain();

    // Random traffic with random output stalls.
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          op = ($urandom_range(0, 9) < 9) ? int'($urandom_range(0, 4)) : int'($urandom_range(5, 7));
          send_m(op, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
          if ($urandom_range(0, 3) == 0) cyc(int'($urandom_range(1, 2)));
        end
        rand_done = 1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1;
          bus.out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    bus.out_ready = 1'b1;
    drain();
    chk("final_out_valid", int'(bus.out_valid), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
